// File: rtl/vga_frame_reader.sv
// vga_frame_reader: VGA timing plus image-port scan-out, grayscale pixels with one-pixel output pipeline.
// Optional VGA_BORDER_EN draws a white 1-pixel frame just outside the stored image.
module vga_frame_reader #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [18:0] vgaAdress,
  input  logic [7:0]  ImageData,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        active,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_IMG  = HW'(IMG_W);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_IMG  = VW'(IMG_H);
  localparam logic [19:0]   ROW_W  = 20'(IMG_W);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [19:0]   row_q, row_d, addr_sum;
  logic [18:0]   addr_q, addr_d;
  logic          hs_q, hs_d, vs_q, vs_d, act_q, act_d, fs_q, fs_d;
  logic [3:0]    pix_q, pix_d;
  logic          tick, h_wrap, v_wrap, act_now, in_img, border, unused_lo;

  assign unused_lo = ^ImageData[3:0];

`ifdef VGA_BORDER_EN
  assign border = (h_q == H_IMG && v_q <= V_IMG) || (v_q == V_IMG && h_q <= H_IMG);
`else
  assign border = 1'b0;
`endif

  always_comb begin
    tick     = div_q == D_LAST;
    h_wrap   = h_q == H_LAST;
    v_wrap   = v_q == V_LAST;
    div_d    = tick ? '0 : div_q + 1'b1;
    h_d      = !tick ? h_q : h_wrap ? '0 : h_q + 1'b1;
    v_d      = !(tick && h_wrap) ? v_q : v_wrap ? '0 : v_q + 1'b1;
    row_d    = !(tick && h_wrap) ? row_q : v_wrap ? '0 : (v_q < V_IMG) ? row_q + ROW_W : row_q;
    addr_sum = row_d + 20'(h_d);
    addr_d   = (tick && h_d < H_IMG && v_d < V_IMG) ? addr_sum[18:0] : addr_q;
    // Output stage describes the position held before this tick's advance.
    act_now  = h_q < H_ACT && v_q < V_ACT;
    in_img   = h_q < H_IMG && v_q < V_IMG;
    hs_d     = tick ? !(h_q >= H_SS && h_q < H_SE) : hs_q;
    vs_d     = tick ? !(v_q >= V_SS && v_q < V_SE) : vs_q;
    act_d    = tick ? act_now : act_q;
    pix_d    = !tick ? pix_q : !act_now ? 4'h0 : in_img ? ImageData[7:4] : border ? 4'hF : 4'h0;
    fs_d     = tick && h_wrap && v_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      row_q  <= '0;
      addr_q <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      act_q  <= 1'b0;
      pix_q  <= '0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      row_q  <= row_d;
      addr_q <= addr_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      act_q  <= act_d;
      pix_q  <= pix_d;
      fs_q   <= fs_d;
    end
  end

  assign vgaAdress   = addr_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign active      = act_q;
  assign red         = pix_q;
  assign green       = pix_q;
  assign blue        = pix_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: scoreboard bench on a shrunken timing so whole frames fit in a short run.
module tb_vga_frame_reader;
  localparam int CD = 2;
  localparam int HA = 20, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int IW = 8, IH = 6, FT = HT * VT;

  typedef struct {logic hs; logic vs; logic act; logic [3:0] pix;} exp_t;

  logic clk = 0, rst = 1;
  logic [18:0] vga_adress;
  logic [7:0] img_data = 0;
  logic hsync, vsync, active, frame_start;
  logic [3:0] red, green, blue;
  int tests = 0, failed = 0, e = 0, k = 0, exp_addr = 0;
  exp_t sb[$];

  vga_frame_reader #(.CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst(rst), .vgaAdress(vga_adress), .ImageData(img_data), .hsync(hsync),
    .vsync(vsync), .red(red), .green(green), .blue(blue), .active(active), .frame_start(frame_start));

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(int a);
    return 8'(a * 37 + (a >> 3) + 90);
  endfunction

  always @(posedge clk) img_data <= mem_f(int'(vga_adress));

  function automatic exp_t mk(int h, int v);
    exp_t x;
    logic bd;
`ifdef VGA_BORDER_EN
    bd = (h == IW && v <= IH) || (v == IH && h <= IW);
`else
    bd = 1'b0;
`endif
    x.act = h < HA && v < VA;
    x.hs  = !(h >= HA + HF && h < HA + HF + HS);
    x.vs  = !(v >= VA + VF && v < VA + VF + VS);
    x.pix = !x.act ? 4'h0 : (h < IW && v < IH) ? mem_f(v * IW + h) >> 4 : bd ? 4'hF : 4'h0;
    return x;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h (e=%0d k=%0d)", tag, obs, expv, e, k);
    end
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_addr"}, 32'(vga_adress), 0);
    chk({tag, "_hsync"}, 32'(hsync), 1);
    chk({tag, "_vsync"}, 32'(vsync), 1);
    chk({tag, "_rgb"}, {20'h0, red, green, blue}, 0);
    chk({tag, "_active"}, 32'(active), 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
  endtask

  task automatic step();
    exp_t x;
    int p, h, v;
    @(posedge clk);
    #1;
    if (rst) begin
      e = 0; k = 0; exp_addr = 0;
      sb.delete();
      sb.push_back(mk(0, 0));
      chk_reset_outs("rst");
    end else begin
      e++;
      if (e % CD == 0) begin
        k++;
        p = k % FT; h = p % HT; v = p / HT;
        if (h < IW && v < IH) exp_addr = v * IW + h;
        x = sb.pop_front();
        chk("hsync", 32'(hsync), 32'(x.hs));
        chk("vsync", 32'(vsync), 32'(x.vs));
        chk("active", 32'(active), 32'(x.act));
        chk("red", 32'(red), 32'(x.pix));
        chk("green", 32'(green), 32'(x.pix));
        chk("blue", 32'(blue), 32'(x.pix));
        chk("addr", 32'(vga_adress), 32'(exp_addr));
        chk("frame_start", 32'(frame_start), 32'(p == 0));
        sb.push_back(mk(h, v));
      end else begin
        chk("fs_idle", 32'(frame_start), 0);
        if (k == 0) chk_reset_outs("pre_tick");
      end
    end
  endtask

  initial begin
    repeat (3) step();
    rst = 0;
    while (k < 2 * FT + 3 * HT + 10) step();
    rst = 1;
    step();
    rst = 0;
    while (k < FT + 40) step();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Read-side master of the image port of data memory: generates 640x480@60 VGA timing and drives the 19-bit `vgaAdress` to fetch grayscale pixels.
- Consumes the returned 8-bit `ImageData` and produces registered RGB and sync outputs.
- The processor writes the filtered image through the Mem stage; this block scans it out.
- The image occupies the top-left IMG_W x IMG_H region; all other visible pixels are black.

Parameters:
- CLK_DIV, 2: clk cycles per pixel; legal values are 2..8, and must be >=2 because the memory read takes one clk.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: horizontal sync width.
- H_BP, 48: horizontal back porch.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vertical sync width.
- V_BP, 33: vertical back porch.
- IMG_W, 256: stored image width in pixels; must be <=H_ACTIVE.
- IMG_H, 256: stored image height in lines; must be <=V_ACTIVE, and IMG_W*IMG_H must be <=2^19.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- vgaAdress, output, 19: pixel address to the data-memory image port.
- ImageData, input, 8: pixel byte returned by memory one clk after `vgaAdress`.
- hsync, output, 1: horizontal sync, active low.
- vsync, output, 1: vertical sync, active low.
- red, output, 4: red channel.
- green, output, 4: green channel.
- blue, output, 4: blue channel.
- active, output, 1: high while the displayed pixel is within 640x480.
- frame_start, output, 1: one-clk pulse when the counters wrap to (0,0).

Behaviour:
- Clock and reset: single clock `clk`. `rst` is synchronous and active-high; all state clears on the rising edge while it is asserted.
- Reset values:
  - div_cnt=0, h_cnt=0, v_cnt=0, row_base=0.
  - vgaAdress=0, hsync=1, vsync=1, red/green/blue=0, active=0, frame_start=0.
- Pixel tick:
  - div_cnt counts 0..CLK_DIV-1.
  - pix_tick is asserted in the clk where div_cnt==CLK_DIV-1.
  - The first tick after reset release occurs CLK_DIV clks later.
- Counters, advanced on pix_tick:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800.
  - At wrap, h_cnt returns to 0 and v_cnt increments.
  - v_cnt runs 0..V_TOTAL-1, where V_TOTAL=525, and wraps to 0.
  - frame_start pulses for the one clk in which the counters become (0,0).
- Address generation:
  - vgaAdress is registered on pix_tick for the new (h,v) position: row_base + h whenever h<IMG_W and v<IMG_H; otherwise it holds its last value.
  - row_base increases by IMG_W when h wraps while v<IMG_H, and returns to 0 when v wraps.
  - No multiplier is used.
  - Pixel (IMG_W-1, IMG_H-1) gives the maximum address IMG_W*IMG_H-1.
- Pipeline:
  - Stage A: counters and vgaAdress update on tick k.
  - ImageData is valid from the following clk.
  - Stage B: on tick k+1, outputs register the values for the stage-A position of tick k: hsync, vsync, active, rgb.
  - Latency is therefore exactly one pixel (CLK_DIV clks) from counter position to pins. Syncs are delayed by the same stage, so they stay aligned with the RGB data.
- Sync and active decode:
  - hsync=0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync=0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - active = (h<H_ACTIVE && v<V_ACTIVE).
- Colour:
  - Inside the image region, red=green=blue=ImageData[7:4] (grayscale).
  - In the active area outside the image, rgb=0.
  - When active=0, rgb is forced to 0.
- Boundaries:
  - Last pixel of the last line: the counters wrap to (0,0), vgaAdress=0, and frame_start pulses in the same clk.
  - IMG_W==H_ACTIVE: row_base still advances correctly.
- Reset mid-frame: returns immediately to the reset state, with no partial-pixel output; the next frame starts from address 0.
- `ImageData` is sampled only in the clk after an address update; values in other clks are ignored.

Optional Feature:
- Macro: VGA_BORDER_EN.
- Defined: pixels with h==IMG_W or v==IMG_H (inside the active area, and with the other coordinate <=IMG_W/IMG_H respectively) output rgb=4'hF on all channels. This gives a 1-pixel white frame around the image. Address behaviour is unchanged.
- Undefined: these pixels are black like the rest of the outside region.

Test Plan:
- Reset and timing: hold rst 3 clks then release -> all outputs at reset values until the first tick; with CLK_DIV=2, hsync falls every 1600 clks with a low width of 192 clks, and vsync repeats every 840000 clks with a low width of 3200 clks.
- Addressing: run to pixel h=5, v=2 with IMG_W=256 -> vgaAdress=517. At h=256, v=2 -> vgaAdress holds 767.
- Pipeline: memory model returns ImageData=8'hA7 for address 517 -> red=green=blue=4'hA exactly one pixel (2 clks) after vgaAdress=517, with active=1.
- Frame wrap: run to (799,524) then one tick -> counters (0,0), vgaAdress=0, frame_start high for exactly 1 clk; outputs at h=700 (blanking) show rgb=0 and active=0.
- Mid-frame reset: assert rst at (300,100) -> next clk vgaAdress=0, hsync=vsync=1, rgb=0; after release the first tick addresses 0.
- Border: with VGA_BORDER_EN, pixel (256,10) -> rgb=4'hF on all channels; without it -> rgb=0.
